alu_control_muldiv: RTL and testbench

//  Next-generation ALU control: decodes ALUOp/funct into the ALU control code, plus an

---
 rtl/alu_control_muldiv.sv | 328 ++++++++++++++++++++++++++++++++
 tb/tb_alu_control_muldiv.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_muldiv.sv
// alu_control_muldiv
//   ALU control decode for the MIPS core, plus an iterative multiply/divide
//   sequencer that owns the HI/LO registers and stalls the pipeline while it
//   runs. The decode is purely combinational. Multiply and divide each retire
//   one bit per cycle and finish in a final cycle that writes HI/LO.
//
//   Configuration macro: ALU_CTRL_DIV_EN
//     defined   -> div/divu are decoded and the restoring divider is built
//     undefined -> funct 1A/1B decode as illegal and never start the sequencer
//
// Parameters
//   DATA_W   operand width; HI and LO are DATA_W bits each
//   CTRL_W   ALU control code width (>= 4, codes are zero-extended)
//
// Ports
//   clk, rst      clock and asynchronous active-high reset
//   op, funct     ALUOp from main control and instruction funct field
//   in_valid      the instruction in this stage is real (not a bubble)
//   a, b          rs and rt operands
//   control       ALU control code
//   rd_sel        writeback source: 00 ALU, 01 HI, 10 LO
//   illegal       R-type with an unrecognised funct
//   stall         high while the sequencer is busy
//   md_done       one-cycle pulse in the final sequencer cycle
//   hi, lo        HI/LO registers

module alu_control_muldiv #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [CTRL_W-1:0] control,
  output logic [1:0]        rd_sel,
  output logic              illegal,
  output logic              stall,
  output logic              md_done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_RTYPE = 6'h02;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_SH    = 6'h28;
  localparam logic [5:0] OP_SB    = 6'h29;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_BREAK = 6'h0D;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
`ifdef ALU_CTRL_DIV_EN
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
`endif
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
`ifdef ALU_CTRL_DIV_EN
    S_DIV  = 2'd3,
`endif
    S_FIN  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [3:0]          ctrl_code;
  logic                is_mul_op;
  logic                signed_op;
  logic                start;

  // Sequencer datapath. opa holds the multiplicand (mult) or divisor (div).
  // acc holds {partial product, multiplier} for mult and
  // {remainder, dividend/quotient} for div; it is one bit wider than 2*DATA_W
  // so the shift-add carry has somewhere to live.
  logic [DATA_W-1:0]   opa;
  logic [2*DATA_W:0]   acc;
  logic [CNT_W-1:0]    cnt;
  logic                neg_res;

  logic [DATA_W-1:0]   abs_a;
  logic [DATA_W-1:0]   abs_b;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W:0]   mul_next;
  logic [2*DATA_W-1:0] prod_signed;

`ifdef ALU_CTRL_DIV_EN
  logic                is_div_op;
  logic                is_div;
  logic                neg_rem;
  logic                div_zero;
  logic [DATA_W-1:0]   raw_a;
  logic [DATA_W:0]     div_sh;
  logic [DATA_W:0]     div_diff;
  logic                div_ge;
  logic [2*DATA_W:0]   div_next;
  logic [DATA_W-1:0]   quot_signed;
  logic [DATA_W-1:0]   rem_signed;
`endif

  // Decode depends only on op/funct, never on in_valid or sequencer state.
  always_comb begin
    ctrl_code = 4'b0000;
    rd_sel    = 2'b00;
    illegal   = 1'b0;
    is_mul_op = 1'b0;
    signed_op = 1'b0;
`ifdef ALU_CTRL_DIV_EN
    is_div_op = 1'b0;
`endif
    case (op)
      OP_ADD:   ctrl_code = 4'b0010;
      OP_SUB:   ctrl_code = 4'b0110;
      OP_ORI:   ctrl_code = 4'b0001;
      OP_ANDI:  ctrl_code = 4'b0000;
      OP_ADDIU: ctrl_code = 4'b0100;
      OP_SLTI:  ctrl_code = 4'b0111;
      OP_SLTIU: ctrl_code = 4'b1011;
      OP_LUI:   ctrl_code = 4'b1010;
      OP_SB:    ctrl_code = 4'b1101;
      OP_SH:    ctrl_code = 4'b1100;
      OP_RTYPE: begin
        case (funct)
          F_AND:   ctrl_code = 4'b0000;
          F_OR:    ctrl_code = 4'b0001;
          F_ADD:   ctrl_code = 4'b0010;
          F_JR:    ctrl_code = 4'b0010;
          F_XOR:   ctrl_code = 4'b0011;
          F_ADDU:  ctrl_code = 4'b0100;
          F_SUBU:  ctrl_code = 4'b0101;
          F_SUB:   ctrl_code = 4'b0110;
          F_SLT:   ctrl_code = 4'b0111;
          F_SLTU:  ctrl_code = 4'b1011;
          F_BREAK: ctrl_code = 4'b1111;
          F_MFHI:  rd_sel    = 2'b01;
          F_MFLO:  rd_sel    = 2'b10;
          F_MULT: begin
            ctrl_code = 4'b1000;
            is_mul_op = 1'b1;
            signed_op = 1'b1;
          end
          F_MULTU: begin
            ctrl_code = 4'b1001;
            is_mul_op = 1'b1;
          end
`ifdef ALU_CTRL_DIV_EN
          F_DIV: begin
            ctrl_code = 4'b1110;
            is_div_op = 1'b1;
            signed_op = 1'b1;
          end
          F_DIVU: begin
            ctrl_code = 4'b1110;
            is_div_op = 1'b1;
          end
`endif
          default: illegal = 1'b1;
        endcase
      end
      default: ctrl_code = 4'b0000;
    endcase
  end

  assign control = CTRL_W'(ctrl_code);

`ifdef ALU_CTRL_DIV_EN
  assign start = in_valid & (is_mul_op | is_div_op) & (state == S_IDLE);
`else
  assign start = in_valid & is_mul_op & (state == S_IDLE);
`endif

  assign stall   = (state != S_IDLE);
  assign md_done = (state == S_FIN);

  // Magnitudes for signed ops; MIN maps to itself, which is the correct
  // unsigned magnitude 2^(DATA_W-1).
  assign abs_a = (signed_op & a[DATA_W-1]) ? -a : a;
  assign abs_b = (signed_op & b[DATA_W-1]) ? -b : b;

  // One shift-add step: conditionally add the multiplicand to the upper half,
  // then shift the whole accumulator right, retiring one multiplier bit.
  assign mul_sum     = acc[2*DATA_W:DATA_W] + (acc[0] ? {1'b0, opa} : {(DATA_W+1){1'b0}});
  assign mul_next    = {1'b0, mul_sum, acc[DATA_W-1:1]};
  assign prod_signed = neg_res ? -acc[2*DATA_W-1:0] : acc[2*DATA_W-1:0];

`ifdef ALU_CTRL_DIV_EN
  // One restoring-division step: shift the next dividend bit into the
  // remainder and subtract the divisor if it fits; the fit bit becomes the
  // next quotient bit shifted in at the bottom.
  assign div_sh      = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
  assign div_ge      = (div_sh >= {1'b0, opa});
  assign div_diff    = div_sh - {1'b0, opa};
  assign div_next    = {(div_ge ? div_diff : div_sh), acc[DATA_W-2:0], div_ge};
  assign quot_signed = neg_res ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  assign rem_signed  = neg_rem ? -acc[2*DATA_W-1:DATA_W] : acc[2*DATA_W-1:DATA_W];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_CTRL_DIV_EN
          next_state = is_div_op ? S_DIV : S_MUL;
`else
          next_state = S_MUL;
`endif
        end
      end
      S_MUL: begin
        if (cnt == CNT_W'(1)) next_state = S_FIN;
      end
`ifdef ALU_CTRL_DIV_EN
      S_DIV: begin
        if (cnt == CNT_W'(1)) next_state = S_FIN;
      end
`endif
      S_FIN:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Operand latch on start, per-bit iteration, and HI/LO writeback in FIN.
  // Reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg_res <= 1'b0;
      hi      <= '0;
      lo      <= '0;
`ifdef ALU_CTRL_DIV_EN
      is_div   <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      raw_a    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt     <= CNT_W'(DATA_W);
            neg_res <= signed_op & (a[DATA_W-1] ^ b[DATA_W-1]);
`ifdef ALU_CTRL_DIV_EN
            is_div   <= is_div_op;
            neg_rem  <= signed_op & a[DATA_W-1];
            div_zero <= (b == '0);
            raw_a    <= a;
            if (is_div_op) begin
              opa <= abs_b;
              acc <= {{(DATA_W+1){1'b0}}, abs_a};
            end else begin
              opa <= abs_a;
              acc <= {{(DATA_W+1){1'b0}}, abs_b};
            end
`else
            opa <= abs_a;
            acc <= {{(DATA_W+1){1'b0}}, abs_b};
`endif
          end
        end
        S_MUL: begin
          acc <= mul_next;
          cnt <= cnt - CNT_W'(1);
        end
`ifdef ALU_CTRL_DIV_EN
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt - CNT_W'(1);
        end
`endif
        S_FIN: begin
`ifdef ALU_CTRL_DIV_EN
          if (is_div) begin
            if (div_zero) begin
              lo <= '1;
              hi <= raw_a;
            end else begin
              lo <= quot_signed;
              hi <= rem_signed;
            end
          end else begin
            {hi, lo} <= prod_signed;
          end
`else
          {hi, lo} <= prod_signed;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// tb_alu_control_muldiv
//   Directed bench for alu_control_muldiv (DATA_W=32, CTRL_W=4). Decode
//   vectors are compared directly; mult/div results are pushed into a
//   scoreboard queue when issued and popped by an independent monitor that
//   watches md_done, counts stall cycles, and checks HI/LO one cycle later.

module tb_alu_control_muldiv;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 4;

  logic              clk;
  logic              rst;
  logic [5:0]        op;
  logic [5:0]        funct;
  logic              in_valid;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [CTRL_W-1:0] control;
  logic [1:0]        rd_sel;
  logic              illegal;
  logic              stall;
  logic              md_done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  int tests_run;
  int tests_failed;

  logic [2*DATA_W-1:0] exp_q[$];
  int                  stall_cnt;
  logic                check_pending;
  logic [2*DATA_W-1:0] exp_pending;

  typedef struct packed {
    logic [5:0] op;
    logic [5:0] funct;
    logic [3:0] ctrl;
    logic [1:0] sel;
    logic       ill;
  } dec_t;

  dec_t dec_vec[14];

  alu_control_muldiv #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct    (funct),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .control  (control),
    .rd_sel   (rd_sel),
    .illegal  (illegal),
    .stall    (stall),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input logic v,
                               input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
    @(posedge clk);
    #1;
    op       = o;
    funct    = f;
    in_valid = v;
    a        = av;
    b        = bv;
  endtask

  // Issue one mult/div, queue its expected {hi,lo}, and wait (bounded) for
  // the sequencer to return to idle.
  task automatic runOp(input string name, input logic [5:0] f,
                       input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv,
                       input logic [2*DATA_W-1:0] exp);
    applyStimulus(6'h02, f, 1'b1, av, bv);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!stall) break;
      @(posedge clk);
      #1;
    end
    checkOutput({name, "_complete"}, {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: counts stall cycles, pops the scoreboard on each md_done pulse,
  // and compares HI/LO on the following cycle when the writeback is visible.
  always @(negedge clk) begin
    if (rst) begin
      stall_cnt     = 0;
      check_pending = 1'b0;
    end else begin
      if (check_pending) begin
        checkOutput("hilo", {hi, lo}, exp_pending);
        check_pending = 1'b0;
      end
      if (stall) stall_cnt++;
      if (md_done) begin
        checkOutput("stall_len", 64'(stall_cnt), 64'(DATA_W + 1));
        stall_cnt = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 64'd1, 64'd0);
        end else begin
          exp_pending   = exp_q.pop_front();
          check_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    stall_cnt     = 0;
    check_pending = 1'b0;
    exp_pending   = '0;
    rst      = 1'b1;
    op       = 6'h00;
    funct    = 6'h00;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;

    dec_vec[0]  = '{op: 6'h00, funct: 6'h00, ctrl: 4'b0010, sel: 2'b00, ill: 1'b0};
    dec_vec[1]  = '{op: 6'h0F, funct: 6'h00, ctrl: 4'b1010, sel: 2'b00, ill: 1'b0};
    dec_vec[2]  = '{op: 6'h02, funct: 6'h2B, ctrl: 4'b1011, sel: 2'b00, ill: 1'b0};
    dec_vec[3]  = '{op: 6'h02, funct: 6'h3F, ctrl: 4'b0000, sel: 2'b00, ill: 1'b1};
    dec_vec[4]  = '{op: 6'h02, funct: 6'h10, ctrl: 4'b0000, sel: 2'b01, ill: 1'b0};
    dec_vec[5]  = '{op: 6'h02, funct: 6'h12, ctrl: 4'b0000, sel: 2'b10, ill: 1'b0};
    dec_vec[6]  = '{op: 6'h01, funct: 6'h00, ctrl: 4'b0110, sel: 2'b00, ill: 1'b0};
    dec_vec[7]  = '{op: 6'h29, funct: 6'h00, ctrl: 4'b1101, sel: 2'b00, ill: 1'b0};
    dec_vec[8]  = '{op: 6'h02, funct: 6'h23, ctrl: 4'b0101, sel: 2'b00, ill: 1'b0};
    dec_vec[9]  = '{op: 6'h02, funct: 6'h0D, ctrl: 4'b1111, sel: 2'b00, ill: 1'b0};
    dec_vec[10] = '{op: 6'h3F, funct: 6'h3F, ctrl: 4'b0000, sel: 2'b00, ill: 1'b0};
    dec_vec[11] = '{op: 6'h02, funct: 6'h18, ctrl: 4'b1000, sel: 2'b00, ill: 1'b0};
    dec_vec[12] = '{op: 6'h0B, funct: 6'h00, ctrl: 4'b1011, sel: 2'b00, ill: 1'b0};
`ifdef ALU_CTRL_DIV_EN
    dec_vec[13] = '{op: 6'h02, funct: 6'h1A, ctrl: 4'b1110, sel: 2'b00, ill: 1'b0};
`else
    dec_vec[13] = '{op: 6'h02, funct: 6'h1A, ctrl: 4'b0000, sel: 2'b00, ill: 1'b1};
`endif

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_stall", {63'd0, stall}, 64'd0);
    checkOutput("reset_done", {63'd0, md_done}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    rst = 1'b0;

    // Decode table with in_valid low, so mult entries must not start anything.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(dec_vec[i].op, dec_vec[i].funct, 1'b0, '0, '0);
      #1;
      checkOutput($sformatf("dec%0d_ctrl", i), 64'(control), 64'(dec_vec[i].ctrl));
      checkOutput($sformatf("dec%0d_sel", i), 64'(rd_sel), 64'(dec_vec[i].sel));
      checkOutput($sformatf("dec%0d_ill", i), 64'(illegal), 64'(dec_vec[i].ill));
    end
    @(posedge clk);
    #1;
    checkOutput("dec_no_stall", {63'd0, stall}, 64'd0);

    runOp("mult_m3x7", 6'h18, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
    runOp("multu_ffx2", 6'h19, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    runOp("mult_ffx2", 6'h18, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    runOp("multu_big", 6'h19, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);
    runOp("mult_neg_neg", 6'h18, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'h0000_0000_0000_0006);

`ifdef ALU_CTRL_DIV_EN
    runOp("div_m7d2", 6'h1A, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    runOp("divu_9d0", 6'h1B, 32'd9, 32'd0, 64'h0000_0009_FFFF_FFFF);
    runOp("div_min_m1", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    runOp("divu_100d7", 6'h1B, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
    runOp("div_m5d0", 6'h1A, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF);
`else
    // Without the divider, div must neither stall nor produce a result.
    applyStimulus(6'h02, 6'h1A, 1'b1, 32'd9, 32'd3);
    @(posedge clk);
    #1;
    checkOutput("div_disabled_stall", {63'd0, stall}, 64'd0);
    in_valid = 1'b0;
`endif

    // Reset in the middle of a mult: state and HI/LO clear immediately,
    // and the aborted operation is never reported.
    applyStimulus(6'h02, 6'h18, 1'b1, 32'd5, 32'd6);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    checkOutput("midop_stall_before", {63'd0, stall}, 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("midop_rst_stall", {63'd0, stall}, 64'd0);
    checkOutput("midop_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    runOp("mult_after_rst", 6'h18, 32'd5, 32'd6, 64'd30);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
